pi_bus_responder: RTL and testbench
===================================

Name: pi_bus_responder

Overview:
- Memory-side responder to the 16-phase bus timing generator.
- Holds one pending Pi-originated read/write request and waits for the Pi access window (pi_select/pi_strobe).
- Drives the shared SRAM address, data and control lines during that window, then captures read data and signals completion.
- Sits between the Pi request interface (SPI command decoder) and the SRAM pins. CPU and IO windows are ignored.

Parameters:
ADDR_WIDTH, 17, SRAM address width (128 KiB).
DATA_WIDTH, 8, SRAM data width.

Ports:
clk16  in  1  16 MHz system clock; all logic on posedge.
reset_n  in  1  synchronous, active-low reset.
pi_select  in  1  Pi window from the timing generator; high for 2 consecutive cycles every 16.
pi_strobe  in  1  Pi strobe from the timing generator; high in the first cycle of pi_select only.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  request address.
req_wr_data  in  DATA_WIDTH  write data.
done  out  1  one-cycle completion pulse.
rd_data  out  DATA_WIDTH  last read result; holds until the next read completes.
ram_addr  out  ADDR_WIDTH  SRAM address.
ram_data_out  out  DATA_WIDTH  SRAM write data.
ram_data_oe  out  1  tristate enable for ram_data_out.
ram_data_in  in  DATA_WIDTH  SRAM read data.
ram_ce_n  out  1  chip enable, active-low.
ram_oe_n  out  1  output enable, active-low.
ram_we_n  out  1  write enable, active-low.

Behaviour:
- Clock and reset: clk16 is the only clock. reset_n is synchronous and active-low.
- Reset values: state=IDLE, req_ready=1, done=0, rd_data=0, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data_oe=0. Latched request fields reset to 0.
- select_q: pi_select registered once per clock. window_start = pi_select & ~select_q (combinational).
- State IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/wr_data and move to PENDING.
  - req_ready is deasserted in every other state. req_* inputs are ignored outside IDLE.
- State PENDING:
  - On window_start, move to ACTIVE.
  - A request accepted in the same cycle as a window_start misses that window and waits for the next one.
- State ACTIVE:
  - If pi_select=1 and pi_strobe=0: this is the capture cycle. rd_data <= ram_data_in for reads only (writes leave rd_data unchanged). done <= 1. Move to IDLE.
  - If pi_select=0 (malformed window): return to PENDING and retry at the next window_start. No done pulse.
- done is high for exactly one cycle, in the cycle after capture. A new request can be accepted in that same cycle.
- RAM outputs (combinational from the registered state and inputs). Let grant = (PENDING & window_start) | ACTIVE.
  - ram_ce_n = ~(grant & pi_select).
  - ram_oe_n = ~(grant & pi_select & ~we).
  - ram_we_n = ~(grant & pi_select & we & pi_strobe).
  - ram_data_oe = grant & pi_select & we.
  - ram_addr = latched addr. ram_data_out = latched wr_data.
  - Result: address and data are stable one full cycle around the we_n pulse. oe_n is never low while data_oe=1.
- Latency from the accepting edge to the done cycle:
  - Minimum 3 cycles (window_start in the first PENDING cycle).
  - Maximum 18 cycles (window_start in the accept cycle itself).
- Protocol faults:
  - pi_strobe high while pi_select low: ignored.
  - pi_select held high beyond 2 cycles: no second access, because the capture edge already moved the state to IDLE.
- Reset mid-operation: the request is dropped without a done pulse. RAM controls deassert in the cycle after the reset edge.

Decomposition:
- Shared package pet_bus_pkg holds:
  - state encoding localparams (IDLE, PENDING, ACTIVE);
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - window phase constants (PI_WINDOW_LEN=2, FRAME_LEN=16), also used by the timing generator.
- No sub-module needed; a single module of about 150 lines. The bench reuses the existing timing generator to drive pi_select/pi_strobe.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles mid-frame -> all ram_*_n=1, ram_data_oe=0, req_ready=1, done=0, rd_data=0.
2. Write: req_we=1, addr=0x1_2345, data=0xA5 accepted 5 cycles before window_start -> ram_we_n low for exactly one cycle coincident with pi_strobe. ram_addr=0x12345 and ram_data_out=0xA5 throughout both select cycles. done 2 cycles after window_start.
3. Read: addr=0x00FFF, SRAM model returns 0x3C -> ram_oe_n low for both select cycles, ram_we_n stays high, rd_data=0x3C and done=1 in the same cycle. rd_data holds 0x3C through a following write.
4. Worst-case latency: request accepted in the window_start cycle -> no RAM activity in that window. done exactly 18 cycles after acceptance.
5. Back-to-back: a second request presented while done=1 -> accepted that cycle and serviced in the next frame (16 cycles later). No overlap of ce_n between the two accesses.
6. Malformed window: force pi_select low after 1 cycle while ACTIVE -> no done, state returns to PENDING, access completes correctly in the next window. Also reset asserted while ACTIVE -> no done; req_ready=1 after reset.

Source files
------------

// File: rtl/pet_bus_pkg.sv
// pet_bus_pkg: shared bus widths, Pi window timing and responder state encoding
// Contents: ADDR_WIDTH/DATA_WIDTH defaults, PI_WINDOW_LEN/FRAME_LEN frame constants, state_t.
package pet_bus_pkg;
  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 8;
  localparam int PI_WINDOW_LEN = 2;
  localparam int FRAME_LEN = 16;
  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;
endpackage

// File: rtl/pi_bus_responder_if.sv
// pi_bus_responder_if: Pi request handshake, Pi window timing and SRAM pin bundle
// master: request source, timing generator and SRAM side; slave: the responder.
// Signals: pi_select/pi_strobe window, req_* request handshake, done/rd_data completion, ram_* SRAM pins.
interface pi_bus_responder_if
  import pet_bus_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
);
  logic pi_select, pi_strobe;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wr_data;
  logic done;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_out, ram_data_in;
  logic ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
  modport master (
    output pi_select, pi_strobe, req_valid, req_we, req_addr, req_wr_data, ram_data_in,
    input req_ready, done, rd_data, ram_addr, ram_data_out, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n
  );
  modport slave (
    input pi_select, pi_strobe, req_valid, req_we, req_addr, req_wr_data, ram_data_in,
    output req_ready, done, rd_data, ram_addr, ram_data_out, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/pi_bus_responder.sv
// pi_bus_responder: holds one Pi SRAM request and performs it in the next Pi window of the bus frame
// Ports: clk16 system clock, reset_n sync active-low reset, bus (slave modport) carrying
// the request handshake, Pi window timing, completion pulse/read data and SRAM pins.
module pi_bus_responder
  import pet_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = pet_bus_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = pet_bus_pkg::DATA_WIDTH
) (
  input logic clk16,
  input logic reset_n,
  pi_bus_responder_if.slave bus
);
  state_t state_q, state_d;
  logic select_q, we_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q, rd_data_q;
  logic window_start, accept, capture, grant, drive;
  always_comb begin
    window_start = bus.pi_select & ~select_q;
    accept = state_q == IDLE && bus.req_valid;
    // second select cycle is where read data is valid and the write pulse has ended
    capture = state_q == ACTIVE && bus.pi_select && !bus.pi_strobe;
    // the window's first cycle is already ours while still PENDING, so the strobe cycle is driven
    grant = (state_q == PENDING && window_start) || state_q == ACTIVE;
    drive = grant && bus.pi_select;
    state_d = state_q == IDLE    ? (accept ? PENDING : IDLE) :
              state_q == PENDING ? (window_start ? ACTIVE : PENDING) :
              state_q == ACTIVE  ? (!bus.pi_select ? PENDING : capture ? IDLE : ACTIVE) :
                                   IDLE;
  end
  always_ff @(posedge clk16) begin
    if (!reset_n) begin
      state_q <= IDLE;
      select_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      select_q <= bus.pi_select;
      done_q <= capture;
      if (accept) begin
        we_q <= bus.req_we;
        addr_q <= bus.req_addr;
        wr_data_q <= bus.req_wr_data;
      end
      if (capture && !we_q) rd_data_q <= bus.ram_data_in;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.done = done_q;
  assign bus.rd_data = rd_data_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data_out = wr_data_q;
  assign bus.ram_ce_n = ~drive;
  assign bus.ram_oe_n = ~(drive && !we_q);
  assign bus.ram_we_n = ~(drive && we_q && bus.pi_strobe);
  assign bus.ram_data_oe = drive && we_q;
endmodule

// File: tb/tb_pi_bus_responder.sv
// tb_pi_bus_responder: directed scoreboard bench for pi_bus_responder with a behavioural SRAM
module tb_pi_bus_responder;
  import pet_bus_pkg::*;
  typedef struct {
    int cyc;
    logic [7:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 5;
  int nchk = 0;
  int nerr = 0;
  bit kill = 1'b0;
  exp_t sb[$];
  logic [7:0] sram[int];
  logic [7:0] model[int];
  logic [7:0] last_rd = 8'h00;
  pi_bus_responder_if bus ();
  pi_bus_responder dut (.clk16(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] dflt(int a);
    return 8'(a) ^ 8'hC3;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive_window();
    int ph;
    ph = cyc % FRAME_LEN;
    bus.pi_select = ph < PI_WINDOW_LEN && !(kill && ph == 1);
    bus.pi_strobe = ph == 0;
  endtask
  task automatic next();
    if (bus.ram_we_n === 1'b0) sram[int'(bus.ram_addr)] = bus.ram_data_out;
    @(posedge clk);
    #1;
    cyc++;
    drive_window();
    #1;
    bus.ram_data_in = sram.exists(int'(bus.ram_addr)) ? sram[int'(bus.ram_addr)] : dflt(int'(bus.ram_addr));
    #1;
    chk("oe_with_data_oe", {31'd0, !bus.ram_oe_n && bus.ram_data_oe}, 32'd0);
  endtask
  task automatic issue(input logic we, input logic [16:0] addr, input logic [7:0] data);
    exp_t e;
    chk("req_ready_before", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wr_data = data;
    e.cyc = (cyc / FRAME_LEN + 1) * FRAME_LEN + PI_WINDOW_LEN;
    if (we) begin
      model[int'(addr)] = data;
      e.rd = last_rd;
    end else begin
      e.rd = model.exists(int'(addr)) ? model[int'(addr)] : dflt(int'(addr));
      last_rd = e.rd;
    end
    sb.push_back(e);
    next();
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom);
    bus.req_addr = 17'($urandom);
    bus.req_wr_data = 8'($urandom);
    #1;
    chk("req_ready_after", {31'd0, bus.req_ready}, 32'd0);
  endtask
  task automatic wait_done(input int bound);
    exp_t e;
    for (int i = 0; i < bound; i++) begin
      if (bus.done === 1'b1) begin
        nchk++;
        if (sb.size() == 0) begin
          nerr++;
          $error("FAIL done_unexpected observed=1 expected=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("rd_data", {24'd0, bus.rd_data}, {24'd0, e.rd});
        end
        return;
      end
      next();
    end
    nchk++;
    nerr++;
    $error("FAIL done_timeout observed=no_done expected=done within %0d cycles", bound);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wr_data = '0;
    bus.ram_data_in = '0;
    drive_window();
    repeat (3) next();
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("rst_ce_n", {31'd0, bus.ram_ce_n}, 32'd1);
    chk("rst_oe_n", {31'd0, bus.ram_oe_n}, 32'd1);
    chk("rst_we_n", {31'd0, bus.ram_we_n}, 32'd1);
    chk("rst_data_oe", {31'd0, bus.ram_data_oe}, 32'd0);
    reset_n = 1'b1;
    while (cyc % FRAME_LEN != 11) next();
    issue(1'b1, 17'h12345, 8'hA5);
    while (cyc % FRAME_LEN != 0) next();
    chk("wr_we_n_strobe", {31'd0, bus.ram_we_n}, 32'd0);
    chk("wr_ce_n_0", {31'd0, bus.ram_ce_n}, 32'd0);
    chk("wr_data_oe_0", {31'd0, bus.ram_data_oe}, 32'd1);
    chk("wr_addr_0", {15'd0, bus.ram_addr}, 32'h12345);
    chk("wr_data_0", {24'd0, bus.ram_data_out}, 32'hA5);
    next();
    chk("wr_we_n_1", {31'd0, bus.ram_we_n}, 32'd1);
    chk("wr_ce_n_1", {31'd0, bus.ram_ce_n}, 32'd0);
    chk("wr_data_oe_1", {31'd0, bus.ram_data_oe}, 32'd1);
    chk("wr_addr_1", {15'd0, bus.ram_addr}, 32'h12345);
    chk("wr_data_1", {24'd0, bus.ram_data_out}, 32'hA5);
    wait_done(4);
    next();
    chk("wr_done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("wr_ce_n_after", {31'd0, bus.ram_ce_n}, 32'd1);
    issue(1'b0, 17'h00FFF, 8'h00);
    while (cyc % FRAME_LEN != 0) next();
    chk("rd_oe_n_0", {31'd0, bus.ram_oe_n}, 32'd0);
    chk("rd_we_n_0", {31'd0, bus.ram_we_n}, 32'd1);
    chk("rd_data_oe_0", {31'd0, bus.ram_data_oe}, 32'd0);
    next();
    chk("rd_oe_n_1", {31'd0, bus.ram_oe_n}, 32'd0);
    chk("rd_we_n_1", {31'd0, bus.ram_we_n}, 32'd1);
    wait_done(4);
    chk("rd_value_3c", {24'd0, bus.rd_data}, 32'h3C);
    issue(1'b1, 17'h00200, 8'h77);
    wait_done(20);
    chk("rd_hold_after_write", {24'd0, bus.rd_data}, 32'h3C);
    while (cyc % FRAME_LEN != 0) next();
    issue(1'b0, 17'h12345, 8'h00);
    chk("worst_no_access_ce_n", {31'd0, bus.ram_ce_n}, 32'd1);
    chk("worst_no_access_oe_n", {31'd0, bus.ram_oe_n}, 32'd1);
    wait_done(20);
    issue(1'b1, 17'h00100, 8'h5A);
    chk("b2b_done_drops", {31'd0, bus.done}, 32'd0);
    chk("b2b_ce_n_idle", {31'd0, bus.ram_ce_n}, 32'd1);
    wait_done(20);
    issue(1'b0, 17'h00100, 8'h00);
    wait_done(20);
    issue(1'b0, 17'h00200, 8'h00);
    sb[$].cyc += FRAME_LEN;
    kill = 1'b1;
    while (cyc % FRAME_LEN != 2) next();
    chk("malformed_no_done", {31'd0, bus.done}, 32'd0);
    chk("malformed_pending", {31'd0, bus.req_ready}, 32'd0);
    kill = 1'b0;
    wait_done(20);
    issue(1'b0, 17'h00FFF, 8'h00);
    while (cyc % FRAME_LEN != 0) next();
    chk("rst_active_ce_n", {31'd0, bus.ram_ce_n}, 32'd0);
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    void'(sb.pop_back());
    last_rd = 8'h00;
    chk("rst_mid_ce_n", {31'd0, bus.ram_ce_n}, 32'd1);
    chk("rst_mid_oe_n", {31'd0, bus.ram_oe_n}, 32'd1);
    chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      next();
      chk("rst_mid_no_done", {31'd0, bus.done}, 32'd0);
    end
    chk("rst_mid_rd_data", {24'd0, bus.rd_data}, {24'd0, last_rd});
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
